// File: rtl/lzw_code_packer.sv
// Packs fixed-width LZW codes MSB-first into a continuous bitstream of OUT_WIDTH-bit words.
// An end-of-stream flush drains residual bits zero-padded and pulses flush_done.
module lzw_code_packer #(
  parameter int CODE_WIDTH = 11,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic                  flush,
  output logic [OUT_WIDTH-1:0]  byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  flush_done
);

  localparam int ACC_W = CODE_WIDTH + OUT_WIDTH - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] OUT_CNT  = CNT_W'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] CODE_CNT = CNT_W'(CODE_WIDTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t state;
  state_t next_state;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // code side: the producer holds code_in stable until code_ready is seen.
  // byte side: byte_out/byte_valid come from registers only and hold while !byte_ready.
  assign push     = code_valid && code_ready;
  assign pop      = byte_valid && byte_ready;
  assign byte_out = acc[ACC_W-1 -: OUT_WIDTH];

  always_comb begin
    code_ready = 1'b0;
    byte_valid = 1'b0;
    flush_done = 1'b0;
    next_state = state;
    case (state)
      RUN: begin
        code_ready = (cnt < OUT_CNT);
        byte_valid = (cnt >= OUT_CNT);
        if (flush) next_state = DRAIN;
      end
      DRAIN: begin
        byte_valid = (cnt != '0);
        if (cnt == '0) begin
          next_state = DONE;
        end else if (byte_ready && (cnt <= OUT_CNT)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Bits below the valid region are always zero, so a push can OR the
  // right-shifted code into place instead of using a variable part-select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (push) begin
      acc <= acc | ({code_in, {(OUT_WIDTH-1){1'b0}}} >> cnt);
      cnt <= cnt + CODE_CNT;
    end else if (pop) begin
      acc <= acc << OUT_WIDTH;
      cnt <= (cnt > OUT_CNT) ? (cnt - OUT_CNT) : '0;
    end
  end

endmodule
